// File: rtl/cache_control_nway.sv
// Control FSM for an N-way set-associative write-back/write-allocate cache.
// Keeps per-set tree pseudo-LRU state and picks the eviction victim on a miss.
module cache_control_nway #(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int WAY_W = $clog2(WAYS),
  parameter int SET_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic [SET_W-1:0] set_idx,
  input  logic [WAYS-1:0]  hit_vec,
  input  logic [WAYS-1:0]  valid_vec,
  input  logic [WAYS-1:0]  dirty_vec,
  input  logic             pmem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             pmem_addr_sel,
  output logic [WAY_W-1:0] way_sel,
  output logic             load_data,
  output logic             load_tag,
  output logic             set_valid,
  output logic             set_dirty,
  output logic             clr_dirty
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] FILL      = 2'd2;

  // Tree nodes are heap-numbered 1..WAYS-1; a 0 bit points toward the lower half.
  function automatic logic [WAY_W-1:0] plru_victim(
    input logic [WAYS-1:1] t
  );
    logic [WAY_W-1:0] n;
    n = WAY_W'(1);
    for (int l = 0; l < WAY_W; l++)
      n = (n << 1) | WAY_W'(t[n]);
    return n;
  endfunction

  function automatic logic [WAYS-1:1] plru_touch(
    input logic [WAYS-1:1]  t,
    input logic [WAY_W-1:0] w
  );
    logic [WAY_W-1:0] n;
    logic [WAY_W-1:0] ws;
    logic [WAYS-1:1]  r;
    r  = t;
    n  = WAY_W'(1);
    ws = w;
    for (int l = 0; l < WAY_W; l++) begin
      r[n] = ~ws[WAY_W-1];
      n    = (n << 1) | WAY_W'(ws[WAY_W-1]);
      ws   = ws << 1;
    end
    return r;
  endfunction

  logic [1:0]                 state_q, state_d;
  logic [WAY_W-1:0]           victim_q, victim_d;
  logic [SETS-1:0][WAYS-1:1]  plru_q, plru_d;

  logic             req;
  logic             hit;
  logic             any_inv;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] victim_sel;

  assign req = mem_read | mem_write;
  assign hit = |hit_vec;

  // Downward scan leaves the lowest matching index.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = WAY_W'(i);
      if (!valid_vec[i]) begin
        inv_way = WAY_W'(i);
        any_inv = 1'b1;
      end
    end
  end

  assign victim_sel = any_inv ? inv_way
                              : plru_victim(plru_q[set_idx]);

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    plru_d        = plru_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    way_sel       = '0;
    load_data     = 1'b0;
    load_tag      = 1'b0;
    set_valid     = 1'b0;
    set_dirty     = 1'b0;
    clr_dirty     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          way_sel   = hit_way;
          mem_resp  = 1'b1;
          load_data = mem_write;
          set_dirty = mem_write;
          plru_d[set_idx] = plru_touch(plru_q[set_idx], hit_way);
        end else if (req) begin
          victim_d = victim_sel;
          if (valid_vec[victim_sel] && dirty_vec[victim_sel])
            state_d = WRITEBACK;
          else
            state_d = FILL;
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim_q;
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        if (pmem_resp) begin
          load_data = 1'b1;
          load_tag  = 1'b1;
          set_valid = 1'b1;
          clr_dirty = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      way_sel       = '0;
      load_data     = 1'b0;
      load_tag      = 1'b0;
      set_valid     = 1'b0;
      set_dirty     = 1'b0;
      clr_dirty     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
      plru_q   <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      plru_q   <= plru_d;
    end
  end

  // More than one tag match means the datapath is already corrupt.
  a_onehot_hit: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE && req) |-> $onehot0(hit_vec));

endmodule

// File: doc/cache_control_nway.md
Name: cache_control_nway

Overview:
- Control FSM for a parametrised N-way set-associative, write-back, write-allocate cache.
- Sits between the CPU-side memory interface and physical memory. Drives load enables and way selects into the cache datapath.
- Owns per-set tree pseudo-LRU state and victim selection, which the direct-mapped predecessor lacks.

Parameters:
WAYS, 4, associativity; power of two, 2..8
SETS, 8, number of sets; power of two >= 2
WAY_W, $clog2(WAYS), derived width of way index
SET_W, $clog2(SETS), derived width of set index

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_resp  out  1  request complete
set_idx  in  SET_W  set index of current request
hit_vec  in  WAYS  per-way tag match AND valid
valid_vec  in  WAYS  valid bits of indexed set
dirty_vec  in  WAYS  dirty bits of indexed set
pmem_resp  in  1  physical memory transaction done
pmem_read  out  1  line fill request
pmem_write  out  1  line writeback request
pmem_addr_sel  out  1  0 = request tag, 1 = victim tag for pmem address
way_sel  out  WAY_W  way targeted by datapath loads/reads
load_data  out  1  write line/word into way_sel
load_tag  out  1  write tag into way_sel
set_valid  out  1  set valid bit of way_sel
set_dirty  out  1  set dirty bit of way_sel
clr_dirty  out  1  clear dirty bit of way_sel

Behaviour:
- Reset: state = IDLE, all PLRU bits = 0, victim register = 0.
- While rst is high, all outputs are 0. Reset mid-transaction abandons it; the next request starts fresh.
- Outputs are combinational from state and inputs. Default value of every output is 0.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE, with no request: outputs idle.
- IDLE, request with hit (hit_vec has exactly one bit set):
  - way_sel = index of the hit bit; mem_resp = 1 in the same cycle.
  - On a write, additionally load_data = 1 and set_dirty = 1.
  - PLRU of set_idx updated at the clock edge to mark way_sel most-recently-used. Stay IDLE.
- IDLE, request with miss (hit_vec == 0):
  - Victim = lowest-index way with valid_vec = 0. If all ways are valid, victim = PLRU victim of set_idx.
  - Victim is latched at the edge.
  - Next state = WRITEBACK if victim is valid and dirty, else FILL.
  - mem_resp = 0.
- WRITEBACK:
  - pmem_write = 1, pmem_addr_sel = 1, way_sel = latched victim.
  - Hold until pmem_resp = 1, then go to FILL.
- FILL:
  - pmem_read = 1, pmem_addr_sel = 0, way_sel = latched victim.
  - On pmem_resp = 1, in the same cycle: load_data = 1, load_tag = 1, set_valid = 1, clr_dirty = 1. Next state = IDLE.
  - PLRU is not touched here; the re-lookup hit in IDLE updates it.
- After FILL, the held request hits in IDLE. Miss latency = 1 cycle to issue + pmem latency(s) + 1 hit cycle.
- A request dropped while in WRITEBACK or FILL is a protocol violation. The FSM still completes the pmem transaction and returns to IDLE; it never aborts pmem mid-transaction.
- mem_read and mem_write both high: treat as a write.
- hit_vec with more than one bit set: undefined datapath state. way_sel = lowest set bit, and a simulation assertion fires.
- PLRU: WAYS-1 bits per set, binary tree encoding.
  - Access to way w sets each node on w's path to point away from w.
  - Victim = leaf reached by following the node pointers from the root.
  - WAYS = 2 degenerates to true LRU.
- Only the set addressed by set_idx is updated in a given cycle.

Test Plan:
- Cold read: WAYS = 4, reset, read set 3 with all valid = 0 -> FILL on way 0 with no WRITEBACK; pmem_read held until pmem_resp; FILL-cycle strobes load_data/load_tag/set_valid/clr_dirty = 1; next cycle, hit_vec = 0001 gives mem_resp = 1.
- Write hit: hit_vec = 0100 with mem_write -> same cycle mem_resp = 1, way_sel = 2, load_data = 1, set_dirty = 1; no pmem activity.
- PLRU order: set 0 all valid, hits on ways 0, 1, 2, 3 in sequence, then a miss -> victim = way 0. Repeat with hits 2, 0, 3, 1 -> victim = way 2 (tree PLRU check).
- Dirty eviction: all valid, victim way 1 dirty -> WRITEBACK with pmem_addr_sel = 1 and pmem_write held 5 cycles until pmem_resp; then FILL; total miss-to-mem_resp cycle count matches the latency formula.
- Reset in FILL: assert rst mid-FILL -> next cycle all outputs 0, state IDLE; a subsequent miss to the same set picks victim way 0 (PLRU cleared).
- Per-set isolation: SETS = 8, hits on set 5 ways 3, 2, 1 -> set 6's PLRU victim stays way 0.
